sum_accumulator: RTL
====================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter N_SUMS, default 4, number of adder results accumulated per frame (legal 1..15).
REQ-002 Parameter ACC_W, default 8, accumulator width in bits (legal 6..16).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sum_in  input  5  unsigned result from upstream 4-bit ripple-carry adder (carry in bit 4).
REQ-006 in_valid  input  1  sum_in is valid this cycle.
REQ-007 in_ready  output  1  block accepts sum_in this cycle.
REQ-008 start  input  1  single-cycle pulse; begin a new frame.
REQ-009 acc_out  output  ACC_W  accumulated frame result.
REQ-010 out_valid  output  1  acc_out holds a completed frame result.
REQ-011 out_ready  input  1  downstream consumes acc_out.
REQ-012 count  output  4  number of sums accepted in the current frame.
REQ-013 ovf  output  1  sticky overflow flag for the current frame.

Function
REQ-014 FSM SHALL have three states: IDLE, ACCUM, HOLD.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM, clearing acc_out, count and ovf on the same edge.
REQ-016 ACCUM: in_ready=1; sample accepted when in_valid and in_ready are both 1; acc_out <= acc_out + zero-extended sum_in; count <= count+1.
REQ-017 ACCUM: cycles with in_valid=0 SHALL leave acc_out, count and ovf unchanged; no timeout.
REQ-018 On acceptance of sample number N_SUMS, FSM -> HOLD; out_valid SHALL be 1 from the next cycle (one-cycle latency after the last accepted sample).
REQ-019 HOLD: in_ready=0, out_valid=1; acc_out, count and ovf SHALL remain stable until out_ready=1.
REQ-020 HOLD with out_ready=1 and start=0 -> IDLE; with out_ready=1 and start=1 -> ACCUM with acc_out, count and ovf cleared (back-to-back frames).
REQ-021 start SHALL be ignored in ACCUM, and in HOLD while out_ready=0.
REQ-022 Addition carry out of bit ACC_W-1 SHALL set ovf; ovf stays set until the next frame clears it.
REQ-023 With ACC_W=8 and N_SUMS<=8, overflow is impossible (8x30=240<256); ovf SHALL then read 0.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, acc_out=0, count=0, ovf=0, out_valid=0, in_ready=0, regardless of clock.
REQ-025 Reset asserted mid-frame (ACCUM or HOLD) SHALL discard the partial/completed result; after release the block waits in IDLE for start.
REQ-026 Release of rst_n SHALL take effect only at a clock edge; no sample accepted in the release cycle unless start has been seen.

Configuration
REQ-027 Macro ACCUM_SAT_EN: when defined, an overflowing addition SHALL clamp acc_out to all-ones (2^ACC_W-1) and hold it there for the rest of the frame, ovf still set.
REQ-028 When ACCUM_SAT_EN is undefined, acc_out SHALL wrap modulo 2^ACC_W and ovf SHALL still be set.

Verification
REQ-029 N_SUMS=4, ACC_W=8: start, sums 3,9,27,30 with in_valid continuous -> out_valid one cycle after 4th, acc_out=69 (0x45), count=4, ovf=0.
REQ-030 Same frame with in_valid low 3 cycles between each sample -> identical acc_out=69; count advances only on accepted samples.
REQ-031 ACC_W=6, sums 30,30,30,30 -> without ACCUM_SAT_EN acc_out=56, ovf=1; with ACCUM_SAT_EN acc_out=63, ovf=1.
REQ-032 Completed frame, out_ready=0 for 5 cycles -> out_valid=1 and acc_out stable all 5 cycles; out_ready=1 with start=1 -> next cycle ACCUM, acc_out=0, count=0, in_ready=1.
REQ-033 rst_n pulsed low after 2 accepted samples -> acc_out=0, count=0, out_valid=0 immediately; new frame of sums 1,2,3,4 -> acc_out=10.
REQ-034 start pulsed during ACCUM after 1 sample -> ignored; frame completes with the correct sum of all N_SUMS samples.

Source files
------------

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums N_SUMS upstream adder results into an ACC_W-bit register and holds the result until consumed.
// Optional macro ACCUM_SAT_EN: clamp acc_out to all-ones on overflow instead of wrapping.
module sum_accumulator #(
  parameter int unsigned N_SUMS = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       count,
  output logic             ovf
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SUMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               ovf_nxt;
  logic               in_ready_nxt;
  logic               out_valid_nxt;
  logic [SUM_W-1:0]   sum_ext;
  logic               carry;
  logic               accept;

  // One extra bit exposes the carry out of the accumulator MSB.
  assign sum_ext = {1'b0, acc_out} + SUM_W'(sum_in);
  assign carry   = sum_ext[ACC_W];
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_out   <= acc_nxt;
      count     <= count_nxt;
      ovf       <= ovf_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Handshake flags are registered copies of the next state's decode.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_out;
    count_nxt = count;
    ovf_nxt   = ovf;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
`ifdef ACCUM_SAT_EN
          acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
          acc_nxt = sum_ext[ACC_W-1:0];
`endif
          count_nxt = count + CNT_W'(1);
          if (carry) ovf_nxt = 1'b1;
          if (count == LAST_IDX) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == ACCUM);
    out_valid_nxt = (state_nxt == HOLD);
  end

endmodule
